// File: rtl/snake_pkg.sv
// Shared constants for the snake game: direction codes, button indices and
// the direction-reversal helper used by the input stage.
package snake_pkg;

    localparam logic [3:0] DIR_UP    = 4'd0;
    localparam logic [3:0] DIR_DOWN  = 4'd1;
    localparam logic [3:0] DIR_LEFT  = 4'd2;
    localparam logic [3:0] DIR_RIGHT = 4'd3;
    localparam logic [3:0] DIR_RESET = DIR_RIGHT;

    localparam int NUM_BTNS  = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PAUSE = 4;

    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        case (dir)
            DIR_UP:    opposite_dir = DIR_DOWN;
            DIR_DOWN:  opposite_dir = DIR_UP;
            DIR_LEFT:  opposite_dir = DIR_RIGHT;
            DIR_RIGHT: opposite_dir = DIR_LEFT;
            default:   opposite_dir = dir;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, stable-count debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic             db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d      = raw;
        s2_d      = s1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = cnt_q;
        // Any sample agreeing with the current level restarts the stability count.
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake game input stage: five debounced buttons drive a registered direction
// code (with priority and reversal rejection) and a registered pause toggle.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    output logic [3:0] moveState,
    output logic       isPaused
);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] press;

    assign raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    logic [3:0] move_q, move_d;
    logic       paused_q, paused_d;
    logic [3:0] cand;
    logic       cand_vld;

    always_comb begin
        move_d   = move_q;
        paused_d = paused_q;
        cand     = move_q;
        cand_vld = 1'b1;
        // Only the highest-priority press is considered; the rest are dropped.
        if (press[BTN_UP]) begin
            cand = DIR_UP;
        end else if (press[BTN_DOWN]) begin
            cand = DIR_DOWN;
        end else if (press[BTN_LEFT]) begin
            cand = DIR_LEFT;
        end else if (press[BTN_RIGHT]) begin
            cand = DIR_RIGHT;
        end else begin
            cand_vld = 1'b0;
        end
        // Direction is gated by the pause state before any toggle this cycle.
        if (!paused_q && cand_vld && (cand != opposite_dir(move_q))) begin
            move_d = cand;
        end
        if (press[BTN_PAUSE]) begin
            paused_d = ~paused_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            move_q   <= DIR_RESET;
            paused_q <= 1'b0;
        end else begin
            move_q   <= move_d;
            paused_q <= paused_d;
        end
    end

    assign moveState = move_q;
    assign isPaused  = paused_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl with DEBOUNCE_CYCLES = 4: directed scenarios with
// literal expectations plus randomized button traffic against a window model.
module tb_snake_input_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_pause = 1'b0;
    logic [3:0] moveState;
    logic       isPaused;

    int checks   = 0;
    int failures = 0;

    snake_input_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_pause(btn_pause),
        .moveState(moveState),
        .isPaused (isPaused)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge; a level flips once the N
    // synchronised samples preceding an edge all disagree with it.
    logic [N+1:0] hist [5];
    logic         db_m [5];
    logic         press_m [5];
    logic [3:0]   move_m = 4'd3;
    logic         paused_m = 1'b0;
    logic         model_valid = 1'b0;

    function automatic logic [3:0] opp(input logic [3:0] d);
        case (d)
            4'd0: return 4'd1;
            4'd1: return 4'd0;
            4'd2: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [4:0] rawv;
        logic       nd;
        rawv = {btn_pause, btn_right, btn_left, btn_down, btn_up};
        if (reset) begin
            move_m      = 4'd3;
            paused_m    = 1'b0;
            model_valid = 1'b1;
            for (int b = 0; b < 5; b++) begin
                hist[b]    = '0;
                db_m[b]    = 1'b0;
                press_m[b] = 1'b0;
            end
        end else begin
            if (!paused_m) begin
                for (int b = 0; b < 4; b++) begin
                    if (press_m[b]) begin
                        if (4'(b) != opp(move_m)) move_m = 4'(b);
                        break;
                    end
                end
            end
            if (press_m[4]) paused_m = ~paused_m;
            for (int b = 0; b < 5; b++) begin
                nd = db_m[b];
                if (!db_m[b] && hist[b][N:1] == {N{1'b1}}) nd = 1'b1;
                else if (db_m[b] && hist[b][N:1] == {N{1'b0}}) nd = 1'b0;
                press_m[b] = nd & ~db_m[b];
                db_m[b]    = nd;
                hist[b]    = {hist[b][N:0], rawv[b]};
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (moveState !== move_m) begin
                failures++;
                $display("FAIL model_moveState t=%0t got=%0d exp=%0d", $time, moveState, move_m);
            end
            checks++;
            if (isPaused !== paused_m) begin
                failures++;
                $display("FAIL model_isPaused t=%0t got=%0d exp=%0d", $time, isPaused, paused_m);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_pause, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_btns(5'b0);
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic press_btns(input logic [4:0] m);
        set_btns(m);
        cyc(10);
        set_btns(5'b0);
        cyc(10);
    endtask

    initial begin
        // Reset and latency
        cyc(3);
        reset = 1'b0;
        btn_up = 1'b1;
        chk("reset_move", moveState, 3);
        chk("reset_pause", isPaused, 0);
        cyc(6);
        chk("latency_edge6", moveState, 3);
        cyc(1);
        chk("latency_edge7", moveState, 0);
        btn_up = 1'b0;
        cyc(10);

        // Glitch rejection
        do_reset();
        btn_left = 1'b1;
        cyc(3);
        btn_left = 1'b0;
        cyc(20);
        chk("glitch_left", moveState, 3);

        // Reversal rejection
        press_btns(5'b00100);
        chk("reverse_left", moveState, 3);
        press_btns(5'b00010);
        chk("down_accept", moveState, 1);
        press_btns(5'b00001);
        chk("reverse_up", moveState, 1);

        // Priority
        do_reset();
        press_btns(5'b00111);
        chk("priority_up", moveState, 0);

        // Pause gating
        do_reset();
        press_btns(5'b10000);
        chk("pause_on", isPaused, 1);
        press_btns(5'b00001);
        chk("paused_up_dropped", moveState, 3);
        press_btns(5'b10000);
        chk("pause_off", isPaused, 0);
        chk("unpause_move", moveState, 3);
        press_btns(5'b00001);
        chk("up_after_unpause", moveState, 0);

        // Held buttons give exactly one press
        do_reset();
        btn_right = 1'b1;
        cyc(50);
        chk("held_right", moveState, 3);
        btn_right = 1'b0;
        cyc(10);
        btn_pause = 1'b1;
        cyc(50);
        chk("held_pause_once", isPaused, 1);
        btn_pause = 1'b0;
        cyc(10);

        // Reset mid-debounce
        do_reset();
        btn_left = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(20);
        chk("reset_mid_left", moveState, 3);
        btn_left = 1'b0;
        cyc(10);
        do_reset();
        btn_up = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(6);
        chk("reset_mid_up_edge6", moveState, 3);
        cyc(1);
        chk("reset_mid_up_edge7", moveState, 0);
        btn_up = 1'b0;
        cyc(10);

        // Randomized traffic, compared every cycle by the model process
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            set_btns(5'($urandom_range(0, 31)));
            cyc($urandom_range(1, 12));
            set_btns(5'b0);
            cyc($urandom_range(1, 10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
